// File: rtl/vga_interface.sv
// VGA raster timing master: pixel-rate divider, h/v counters, renderer address
// stage and a one-pixel-delayed output stage driving blanked colour and syncs.
module vga_interface #(
   parameter int CLK_DIV = 4,
   parameter int H_VIS   = 640,
   parameter int H_FP    = 16,
   parameter int H_SYNC  = 96,
   parameter int H_BP    = 48,
   parameter int V_VIS   = 480,
   parameter int V_FP    = 10,
   parameter int V_SYNC  = 2,
   parameter int V_BP    = 33
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [7:0] COLOUR_IN,
   output logic [9:0] ADDRH,
   output logic [8:0] ADDRV,
   output logic [7:0] COLOUR_OUT,
   output logic       HS,
   output logic       VS,
   output logic       FRAME_TICK
);

   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
   localparam logic [9:0] H_VIS_C    = 10'(H_VIS);
   localparam logic [9:0] V_VIS_C    = 10'(V_VIS);
   localparam logic [9:0] HS_FIRST   = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_LAST    = 10'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST   = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_LAST    = 10'(V_VIS + V_FP + V_SYNC - 1);

   logic [DIV_W-1:0] divCnt;
   logic [9:0]       hCount;
   logic [9:0]       vCount;
   logic             pixEn;
   logic             hActive, vActive, hSyncOn, vSyncOn;
   logic             actD, hsD, vsD;

   assign pixEn   = (divCnt == DIV_LAST);
   assign hActive = (hCount < H_VIS_C);
   assign vActive = (vCount < V_VIS_C);
   assign hSyncOn = (hCount >= HS_FIRST) && (hCount <= HS_LAST);
   assign vSyncOn = (vCount >= VS_FIRST) && (vCount <= VS_LAST);

   assign FRAME_TICK = pixEn && (hCount == H_LAST) && (vCount == V_LAST);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)
         divCnt <= '0;
      else if (pixEn)
         divCnt <= '0;
      else
         divCnt <= divCnt + 1'b1;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         hCount <= '0;
         vCount <= '0;
      end else if (pixEn) begin
         if (hCount == H_LAST) begin
            hCount <= '0;
            vCount <= (vCount == V_LAST) ? 10'd0 : vCount + 10'd1;
         end else begin
            hCount <= hCount + 10'd1;
         end
      end
   end

   // Address stage; the flags ride along so the output stage sees the same pixel.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         ADDRH <= '0;
         ADDRV <= '0;
         actD  <= 1'b0;
         hsD   <= 1'b1;
         vsD   <= 1'b1;
      end else if (pixEn) begin
         ADDRH <= hActive ? hCount : 10'd0;
         ADDRV <= vActive ? vCount[8:0] : 9'd0;
         actD  <= hActive && vActive;
         hsD   <= !hSyncOn;
         vsD   <= !vSyncOn;
      end
   end

   // COLOUR_IN has had CLK_DIV-1 cycles to settle since the address changed.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         COLOUR_OUT <= '0;
         HS         <= 1'b1;
         VS         <= 1'b1;
      end else if (pixEn) begin
         COLOUR_OUT <= actD ? COLOUR_IN : 8'h00;
         HS         <= hsD;
         VS         <= vsD;
      end
   end

endmodule

// File: tb/tb_vga_interface.sv
// Randomised scoreboard bench for vga_interface on a shrunken raster; the
// expected pin values come from a pixel-index model of the frame.
module tb_vga_interface;

   localparam int CLK_DIV = 4;
   localparam int H_VIS = 20, H_FP = 3, H_SYNC = 5, H_BP = 4;
   localparam int V_VIS = 6,  V_FP = 2, V_SYNC = 2, V_BP = 3;
   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int FRAME = H_TOT * V_TOT;

   logic       clk = 1'b0;
   logic       rstN = 1'b1;
   logic [7:0] colourIn, colourDrv = 8'h00, rendReg = 8'h00;
   logic       rendMode = 1'b0;
   logic [9:0] addrH;
   logic [8:0] addrV;
   logic [7:0] colourOut;
   logic       hs, vs, frameTick;

   typedef struct {
      logic [9:0] ah;
      logic [8:0] av;
      logic [7:0] col;
      logic       hs;
      logic       vs;
      logic       ft;
   } exp_t;

   exp_t q[$];
   int   nChecks = 0;
   int   nFails = 0;

   vga_interface #(
      .CLK_DIV(CLK_DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) dut (
      .CLK(clk), .RESET_N(rstN), .COLOUR_IN(colourIn), .ADDRH(addrH), .ADDRV(addrV),
      .COLOUR_OUT(colourOut), .HS(hs), .VS(vs), .FRAME_TICK(frameTick)
   );

   always #5 clk = ~clk;

   // Renderer model: one-CLK registered lookup of the column address.
   always @(posedge clk) rendReg <= addrH[7:0];
   assign colourIn = rendMode ? rendReg : colourDrv;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
      end
   endtask

   // Raster position of pixel tick t after reset release.
   function automatic int hOf(input int t);
      return (t % FRAME) % H_TOT;
   endfunction
   function automatic int vOf(input int t);
      return (t % FRAME) / H_TOT;
   endfunction
   function automatic bit isActive(input int t);
      return hOf(t) < H_VIS && vOf(t) < V_VIS;
   endfunction
   function automatic bit inHSync(input int h);
      return h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC;
   endfunction
   function automatic bit inVSync(input int v);
      return v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC;
   endfunction

   task automatic checkReset();
      check("reset ADDRH", 32'(addrH), 0);
      check("reset ADDRV", 32'(addrV), 0);
      check("reset COLOUR_OUT", 32'(colourOut), 0);
      check("reset HS", 32'(hs), 1);
      check("reset VS", 32'(vs), 1);
      check("reset FRAME_TICK", 32'(frameTick), 0);
   endtask

   // Driver: called at the negedge on which reset was released; cycle c ends
   // at the c-th posedge after release. Pushes the pin state expected after it.
   task automatic run(input int nCyc, input bit mode);
      exp_t       last;
      int         t, cn;
      logic [7:0] smp;
      rendMode = mode;
      last = '{ah: 10'd0, av: 9'd0, col: 8'h00, hs: 1'b1, vs: 1'b1, ft: 1'b0};
      for (int c = 0; c < nCyc; c++) begin
         if ((c % CLK_DIV) == CLK_DIV - 1) begin
            t = c / CLK_DIV;
            if (t > 0 && isActive(t - 1))
               smp = mode ? 8'(hOf(t - 1)) : 8'($urandom);
            else
               smp = ($urandom_range(1) == 1) ? 8'hAA : 8'hxx;
            if (!mode) colourDrv = smp;
            last.ah = (hOf(t) < H_VIS) ? 10'(hOf(t)) : 10'd0;
            last.av = (vOf(t) < V_VIS) ? 9'(vOf(t)) : 9'd0;
            if (t == 0) begin
               last.col = 8'h00;
               last.hs  = 1'b1;
               last.vs  = 1'b1;
            end else begin
               last.col = isActive(t - 1) ? smp : 8'h00;
               last.hs  = !inHSync(hOf(t - 1));
               last.vs  = !inVSync(vOf(t - 1));
            end
         end else if (!mode) begin
            colourDrv = 8'($urandom);
         end
         cn = c + 1;
         last.ft = ((cn % CLK_DIV) == CLK_DIV - 1) &&
                   hOf(cn / CLK_DIV) == H_TOT - 1 && vOf(cn / CLK_DIV) == V_TOT - 1;
         q.push_back(last);
         @(negedge clk);
      end
   endtask

   // Async reset assert mid-cycle, immediate check, release on a negedge.
   task automatic pulseReset();
      @(posedge clk);
      #2 rstN = 1'b0;
      #1 checkReset();
      repeat (2) @(negedge clk);
      check("reset hold COLOUR_OUT", 32'(colourOut), 0);
      rstN = 1'b1;
   endtask

   // Monitor: compares every post-edge pin state against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("ADDRH", 32'(addrH), 32'(e.ah));
            check("ADDRV", 32'(addrV), 32'(e.av));
            check("COLOUR_OUT", 32'(colourOut), 32'(e.col));
            check("HS", 32'(hs), 32'(e.hs));
            check("VS", 32'(vs), 32'(e.vs));
            check("FRAME_TICK", 32'(frameTick), 32'(e.ft));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1);
   end

   initial begin
      colourDrv = 8'hFF;
      #1 rstN = 1'b0;
      #1 checkReset();
      repeat (3) @(negedge clk);
      checkReset();
      rstN = 1'b1;
      // two full frames of random colour with blanked X/0xAA stimulus
      run(2 * FRAME * CLK_DIV + 40, 1'b0);
      pulseReset();
      // registered renderer returning the column index
      run(FRAME * CLK_DIV + 40, 1'b1);
      pulseReset();
      // abort mid-frame at line 3, column 10
      run((3 * H_TOT + 10) * CLK_DIV + 2, 1'b0);
      pulseReset();
      // restart from (0,0) and a full frame to the next FRAME_TICK
      run(FRAME * CLK_DIV + 40, 1'b0);
      @(posedge clk);
      #2;
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
